// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end with prefetch FIFO and redirect flush
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    output logic [31:0]              instr_pc_plus_4,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic          accept;
    logic          push;
    logic          pop;

    logic [31:0] word_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] pc4_mem  [DEPTH];

    // Credit counts buffered plus in-flight words so a response always has a free slot.
    assign credit_used = {1'b0, count} + (CW+1)'(inflight);
    assign imem_req    = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr   = fetch_pc;
    assign accept      = imem_req && imem_gnt;
    assign push        = imem_rvalid && inflight && !redirect_valid;
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid     = (count != '0);
    assign q_count         = count;
    assign instr           = instr_valid ? word_mem[rd_ptr] : 32'h0;
    assign instr_pc        = instr_valid ? pc_mem[rd_ptr]   : 32'h0;
    assign instr_pc_plus_4 = instr_valid ? pc4_mem[rd_ptr]  : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (accept) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
                inflight    <= 1'b1;
            end else if (imem_rvalid) begin
                inflight <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            word_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= inflight_pc;
            pc4_mem[wr_ptr]  <= inflight_pc + 32'd4;
        end
    end

endmodule
